sdio_response_source: RTL and testbench
=======================================

// Module: sdio_response_source
// PURPOSE
//  Parametrised byte source feeding sdio_slave's response/write-data port on the 200 MHz domain.
//  Replaces the fixed count-pattern generator with a selectable-mode engine.
//  Modes are PATTERN (count+offset) or BUFFER (bytes preloaded over the UART command bus into an internal FIFO).
//  Sits between uart_rx_controller command decode (command group 3'h3) and sdio_slave.
// PARAMETERS
//  DEPTH_LOG2      9      FIFO depth = 2**DEPTH_LOG2 bytes (power of two)
//  COUNT_WIDTH     9      width of data4_count / remaining counter
//  PATTERN_OFFSET  8'h35  added to remaining[7:0] in PATTERN mode
//  FILL_BYTE       8'hFF  byte emitted on FIFO underrun
// PORTS
//  clock                    in   1            single clock; all logic posedge
//  reset                    in   1            synchronous, active-high
//  dev_command_started      in   1            pulse: dev_command valid, new command
//  dev_command_processing   in   1            high while command payload is streaming
//  dev_command              in   5            0x00 SET_MODE, 0x01 CLEAR, 0x02 LOAD
//  dev_command_data_signal  in   1            pulse: dev_data valid
//  dev_data                 in   8            command payload byte
//  dev_busy                 out  1            high while a transfer is in SERVE state
//  write_data4_strobe       in   1            sdio_slave: host started a write-to-host transfer
//  data4_count              in   COUNT_WIDTH  bytes requested, sampled with write_data4_strobe
//  response_start_write     out  1            1-cycle pulse arming sdio_slave
//  response_data_req        in   1            sdio_slave requests next byte
//  response_data_strobe     out  1            1-cycle pulse: response_data valid
//  response_data            out  8            byte to send
//  response_data_empty      out  1            level: no more bytes for this transfer
//  fifo_level               out  DEPTH_LOG2+1 current FIFO occupancy
//  status_flags             out  2            {underrun, overflow}; sticky, cleared by CLEAR
// BEHAVIOUR
//  Reset: all outputs 0 except response_data_empty=1; mode=PATTERN; FIFO empty; state IDLE.
//  Commands: SET_MODE applies dev_data[0] (0=PATTERN, 1=BUFFER) on its data pulse.
//  CLEAR resets FIFO pointers and flags on dev_command_started.
//  LOAD pushes dev_data on every data pulse while processing.
//  FSM: IDLE -> (write_data4_strobe) ARM -> START -> SERVE -> (remaining==0 on req) DONE -> IDLE.
//   ARM: latch remaining=data4_count. START: response_start_write=1 for one cycle, response_data_empty<=0.
//   SERVE: each response_data_req with remaining>0 -> next cycle response_data_strobe=1, remaining-=1.
//   Data: PATTERN uses remaining[7:0]+PATTERN_OFFSET, computed from the pre-decrement value, mod 256.
//   Data: BUFFER pops the FIFO; if FIFO is empty, emit FILL_BYTE and set underrun.
//   SERVE with response_data_req and remaining==0 -> response_data_empty<=1 (held), go to DONE.
//  Latency: write_data4_strobe -> response_start_write = 2 cycles. Req -> strobe = 1 cycle.
//  data4_count==0: START then immediate empty on first req; no strobe.
//  write_data4_strobe in any non-IDLE state aborts the current transfer and re-enters ARM with the new count.
//  A req in the same cycle is ignored.
//  Req outside SERVE: ignored.
//  FIFO full + push: byte dropped, overflow=1. Push and pop in same cycle: both happen; accepted at full.
//  CLEAR during SERVE: FIFO emptied; subsequent BUFFER pops underrun; transfer continues.
//  SET_MODE during SERVE takes effect on the next byte.
//  fifo_level wraps never; saturates at 2**DEPTH_LOG2. Read/write pointers wrap modulo depth.
//  Reset mid-transfer: return to reset state next cycle; no further strobes.
// CONFIGURATION
//  SDIO_RESP_LOOPBACK_EN defined: adds ports read_byte_strobe (in, 1) and read_byte (in, 8).
//   SET_MODE dev_data[1]=1 enables loopback, which pushes every read_byte into the FIFO (same overflow rules).
//   In that case LOAD data pulses are ignored.
//   This echoes host-written data back on the next read.
//  Not defined: no ports, dev_data[1] ignored, FIFO fed by LOAD only.
// TESTING
//  PATTERN, data4_count=3, 4 reqs -> bytes 8'h38,8'h37,8'h36 each 1 cycle after req; 4th req -> empty=1.
//  BUFFER, LOAD 8'hA1,8'hA2, count=4 -> bytes A1,A2,FF,FF; underrun=1; fifo_level 2->0.
//  LOAD 2**DEPTH_LOG2+1 bytes -> fifo_level=512, overflow=1; last byte dropped; CLEAR -> level 0, flags 0.
//  write_data4_strobe(count=5) during SERVE with 2 sent -> new start_write pulse; 5 more bytes.
//   Pattern restarts at 8'h3A.
//  Reset asserted during SERVE -> next cycle strobe=0, empty=1, dev_busy=0; a req is ignored.
//  SDIO_RESP_LOOPBACK_EN: 3 read_byte pulses 11,22,33 with loopback on -> BUFFER read count=3 returns 11,22,33.

Source files
------------

// File: rtl/sdio_response_source.sv
// Purpose: selectable-mode byte source (PATTERN count+offset, or BUFFER FIFO preloaded over the UART command bus) for sdio_slave.
// Latency: write_data4_strobe -> response_start_write 2 cycles; response_data_req -> response_data_strobe 1 cycle.
// Backpressure: none upstream; bytes are produced only on response_data_req, FIFO full drops pushes and flags overflow.
//
// Ports:
//   clock, reset                      single clock, synchronous active-high reset
//   dev_command_* / dev_data          command decode (group 3'h3): 0x00 SET_MODE, 0x01 CLEAR, 0x02 LOAD
//   dev_busy                          high while the FSM is in SERVE
//   write_data4_strobe, data4_count   host started a write-to-host transfer of data4_count bytes
//   response_start_write              1-cycle pulse arming sdio_slave
//   response_data_req/_strobe/_data   byte request / registered byte reply
//   response_data_empty               level, no more bytes for the current transfer
//   fifo_level, status_flags          FIFO occupancy, sticky {underrun, overflow}
// Optional build macro SDIO_RESP_LOOPBACK_EN adds read_byte_strobe/read_byte; SET_MODE dev_data[1]
// then routes host-written bytes into the FIFO instead of LOAD payload.
module sdio_response_source #(
    parameter int         DEPTH_LOG2     = 9,
    parameter int         COUNT_WIDTH    = 9,
    parameter logic [7:0] PATTERN_OFFSET = 8'h35,
    parameter logic [7:0] FILL_BYTE      = 8'hFF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   dev_command_started,
    input  logic                   dev_command_processing,
    input  logic [4:0]             dev_command,
    input  logic                   dev_command_data_signal,
    input  logic [7:0]             dev_data,
    output logic                   dev_busy,
    input  logic                   write_data4_strobe,
    input  logic [COUNT_WIDTH-1:0] data4_count,
    output logic                   response_start_write,
    input  logic                   response_data_req,
    output logic                   response_data_strobe,
    output logic [7:0]             response_data,
    output logic                   response_data_empty,
`ifdef SDIO_RESP_LOOPBACK_EN
    input  logic                   read_byte_strobe,
    input  logic [7:0]             read_byte,
`endif
    output logic [DEPTH_LOG2:0]    fifo_level,
    output logic [1:0]             status_flags
);

    localparam int               DEPTH      = 1 << DEPTH_LOG2;
    localparam int               LW         = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0]    FULL_LEVEL = LW'(DEPTH);
    localparam logic [4:0]       CMD_SET_MODE = 5'h00;
    localparam logic [4:0]       CMD_CLEAR    = 5'h01;
    localparam logic [4:0]       CMD_LOAD     = 5'h02;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_START,
        S_SERVE,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [4:0]              cmd_q;
    logic [4:0]              cur_cmd;
    logic                    mode_buffer;
    logic [COUNT_WIDTH-1:0]  count_q;
    logic [COUNT_WIDTH-1:0]  remaining;
    logic [7:0]              mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [LW-1:0]           level;
    logic                    underrun;
    logic                    overflow;
    logic                    strobe_q;
    logic [7:0]              data_q;
    logic                    empty_q;

    logic                    serve_byte;
    logic                    serve_end;
    logic                    clear_cmd;
    logic                    set_mode;
    logic                    push_req;
    logic [7:0]              push_dat;
    logic                    push;
    logic                    pop;
    logic                    fifo_empty;
    logic                    fifo_full;

    // ---------------------------------------------------------------
    // Next-state logic. A new write_data4_strobe pre-empts everything,
    // including a request arriving in the same cycle.
    // ---------------------------------------------------------------
    always_comb begin
        next_state = state;
        serve_byte = 1'b0;
        serve_end  = 1'b0;
        if (write_data4_strobe) begin
            next_state = S_ARM;
        end else begin
            case (state)
                S_ARM:   next_state = S_START;
                S_START: next_state = S_SERVE;
                S_SERVE: begin
                    if (response_data_req) begin
                        if (remaining != '0) begin
                            serve_byte = 1'b1;
                        end else begin
                            serve_end  = 1'b1;
                            next_state = S_DONE;
                        end
                    end
                end
                S_DONE:  next_state = S_IDLE;
                default: next_state = state;
            endcase
        end
    end

    // Data pulses arriving in the same cycle as the command start use the new command.
    assign cur_cmd   = dev_command_started ? dev_command : cmd_q;
    assign clear_cmd = dev_command_started && (dev_command == CMD_CLEAR);
    assign set_mode  = dev_command_data_signal && (cur_cmd == CMD_SET_MODE);

`ifdef SDIO_RESP_LOOPBACK_EN
    logic loopback_en;
    assign push_req = loopback_en ? read_byte_strobe
                                  : (dev_command_data_signal && dev_command_processing && (cur_cmd == CMD_LOAD));
    assign push_dat = loopback_en ? read_byte : dev_data;
`else
    assign push_req = dev_command_data_signal && dev_command_processing && (cur_cmd == CMD_LOAD);
    assign push_dat = dev_data;
`endif

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == FULL_LEVEL);
    assign pop        = serve_byte && mode_buffer && !fifo_empty;
    // A simultaneous pop frees a slot, so a push at full is still accepted.
    assign push       = push_req && (!fifo_full || pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            cmd_q       <= '0;
            mode_buffer <= 1'b0;
            count_q     <= '0;
            remaining   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            underrun    <= 1'b0;
            overflow    <= 1'b0;
            strobe_q    <= 1'b0;
            data_q      <= '0;
            empty_q     <= 1'b1;
        end else begin
            state    <= next_state;
            strobe_q <= serve_byte;

            if (dev_command_started) begin
                cmd_q <= dev_command;
            end
            if (set_mode) begin
                mode_buffer <= dev_data[0];
            end
            if (write_data4_strobe) begin
                count_q <= data4_count;
            end
            if (state == S_ARM) begin
                remaining <= count_q;
            end
            if (state == S_START && !write_data4_strobe) begin
                empty_q <= 1'b0;
            end
            if (serve_end) begin
                empty_q <= 1'b1;
            end

            if (serve_byte) begin
                remaining <= remaining - COUNT_WIDTH'(1);
                if (!mode_buffer) begin
                    data_q <= 8'(remaining) + PATTERN_OFFSET;
                end else if (fifo_empty) begin
                    data_q <= FILL_BYTE;
                end else begin
                    data_q <= mem[rd_ptr];
                end
            end

            if (clear_cmd) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
                underrun <= 1'b0;
                overflow <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
                end
                case ({push, pop})
                    2'b10:   level <= level + LW'(1);
                    2'b01:   level <= level - LW'(1);
                    default: level <= level;
                endcase
                if (push_req && !push) begin
                    overflow <= 1'b1;
                end
                if (serve_byte && mode_buffer && fifo_empty) begin
                    underrun <= 1'b1;
                end
            end
        end
    end

`ifdef SDIO_RESP_LOOPBACK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            loopback_en <= 1'b0;
        end else if (set_mode) begin
            loopback_en <= dev_data[1];
        end
    end
`endif

    // Storage needs no reset; pointers and level define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    assign dev_busy             = (state == S_SERVE);
    assign response_start_write = (state == S_START);
    assign response_data_strobe = strobe_q;
    assign response_data        = data_q;
    assign response_data_empty  = empty_q;
    assign fifo_level           = level;
    assign status_flags         = {underrun, overflow};

endmodule

// File: tb/tb_sdio_response_source.sv
module tb_sdio_response_source;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       dev_command_started = 1'b0;
    logic       dev_command_processing = 1'b0;
    logic [4:0] dev_command = '0;
    logic       dev_command_data_signal = 1'b0;
    logic [7:0] dev_data = '0;
    logic       dev_busy;
    logic       write_data4_strobe = 1'b0;
    logic [8:0] data4_count = '0;
    logic       response_start_write;
    logic       response_data_req = 1'b0;
    logic       response_data_strobe;
    logic [7:0] response_data;
    logic       response_data_empty;
    logic [9:0] fifo_level;
    logic [1:0] status_flags;
`ifdef SDIO_RESP_LOOPBACK_EN
    logic       read_byte_strobe = 1'b0;
    logic [7:0] read_byte = '0;
    localparam int EXP_STROBES = 18;
`else
    localparam int EXP_STROBES = 15;
`endif

    int         checks = 0;
    int         errors = 0;
    int         strobe_cnt = 0;
    logic [7:0] exp_q[$];

    sdio_response_source dut (
        .clock                   (clock),
        .reset                   (reset),
        .dev_command_started     (dev_command_started),
        .dev_command_processing  (dev_command_processing),
        .dev_command             (dev_command),
        .dev_command_data_signal (dev_command_data_signal),
        .dev_data                (dev_data),
        .dev_busy                (dev_busy),
        .write_data4_strobe      (write_data4_strobe),
        .data4_count             (data4_count),
        .response_start_write    (response_start_write),
        .response_data_req       (response_data_req),
        .response_data_strobe    (response_data_strobe),
        .response_data           (response_data),
        .response_data_empty     (response_data_empty),
`ifdef SDIO_RESP_LOOPBACK_EN
        .read_byte_strobe        (read_byte_strobe),
        .read_byte               (read_byte),
`endif
        .fifo_level              (fifo_level),
        .status_flags            (status_flags)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobed byte must match the oldest expected byte.
    always @(posedge clock) begin
        #1;
        if (response_data_strobe === 1'b1) begin
            strobe_cnt++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_strobe observed=%0h expected=no_strobe", response_data);
            end
            if (exp_q.size() != 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("resp_data", 32'(response_data), 32'(e));
            end
        end
    end

    task automatic send_cmd(input logic [4:0] c, input int n, input logic [7:0] base);
        @(negedge clock);
        dev_command_started = 1'b1;
        dev_command = c;
        @(negedge clock);
        dev_command_started = 1'b0;
        dev_command_processing = (n != 0);
        for (int i = 0; i < n; i++) begin
            dev_data = 8'(int'(base) + i);
            dev_command_data_signal = 1'b1;
            @(negedge clock);
        end
        dev_command_data_signal = 1'b0;
        dev_command_processing = 1'b0;
    endtask

    // Strobe is driven at N0; ARM at N1, START (start_write) at N2, SERVE at N3.
    task automatic start_xfer(input logic [8:0] cnt);
        @(negedge clock);
        write_data4_strobe = 1'b1;
        data4_count = cnt;
        @(negedge clock);
        write_data4_strobe = 1'b0;
        chk("start_write_arm", 32'(response_start_write), 32'd0);
        @(negedge clock);
        chk("start_write_pulse", 32'(response_start_write), 32'd1);
        @(negedge clock);
        chk("busy_serve", 32'(dev_busy), 32'd1);
        chk("empty_cleared", 32'(response_data_empty), 32'd0);
    endtask

    // One request; the byte (if any) must be strobed exactly one cycle later.
    task automatic req_once(input bit expect_byte, input logic [7:0] b);
        @(negedge clock);
        response_data_req = 1'b1;
        if (expect_byte) exp_q.push_back(b);
        @(negedge clock);
        response_data_req = 1'b0;
        chk("strobe_latency", 32'(response_data_strobe), 32'(expect_byte));
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_strobe", 32'(response_data_strobe), 32'd0);
        chk("rst_data", 32'(response_data), 32'd0);
        chk("rst_empty", 32'(response_data_empty), 32'd1);
        chk("rst_busy", 32'(dev_busy), 32'd0);
        chk("rst_start", 32'(response_start_write), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_flags", 32'(status_flags), 32'd0);
        reset = 1'b0;

        // PATTERN, count 3: 3+35, 2+35, 1+35, then empty
        start_xfer(9'd3);
        req_once(1'b1, 8'h38);
        req_once(1'b1, 8'h37);
        req_once(1'b1, 8'h36);
        req_once(1'b0, 8'h00);
        chk("pat_empty", 32'(response_data_empty), 32'd1);
        req_once(1'b0, 8'h00);   // request outside SERVE is ignored

        // BUFFER with underrun
        send_cmd(5'h00, 1, 8'h01);
        send_cmd(5'h02, 2, 8'hA1);
        chk("buf_level2", 32'(fifo_level), 32'd2);
        start_xfer(9'd4);
        req_once(1'b1, 8'hA1);
        chk("buf_level1", 32'(fifo_level), 32'd1);
        req_once(1'b1, 8'hA2);
        req_once(1'b1, 8'hFF);
        req_once(1'b1, 8'hFF);
        chk("buf_level0", 32'(fifo_level), 32'd0);
        chk("buf_underrun", 32'(status_flags), 32'b10);
        req_once(1'b0, 8'h00);
        chk("buf_empty", 32'(response_data_empty), 32'd1);

        // Overflow: 513 loads into a 512-deep FIFO
        send_cmd(5'h01, 0, 8'h00);
        chk("clr_flags", 32'(status_flags), 32'd0);
        send_cmd(5'h02, 513, 8'h00);
        chk("ovf_level", 32'(fifo_level), 32'd512);
        chk("ovf_flags", 32'(status_flags), 32'b01);
        send_cmd(5'h01, 0, 8'h00);
        chk("clr2_level", 32'(fifo_level), 32'd0);
        chk("clr2_flags", 32'(status_flags), 32'd0);

        // Abort mid-transfer with a new count; same-cycle req ignored
        send_cmd(5'h00, 1, 8'h00);
        start_xfer(9'd7);
        req_once(1'b1, 8'h3C);
        req_once(1'b1, 8'h3B);
        @(negedge clock);
        write_data4_strobe = 1'b1;
        data4_count = 9'd5;
        response_data_req = 1'b1;
        @(negedge clock);
        write_data4_strobe = 1'b0;
        response_data_req = 1'b0;
        chk("abort_req_ignored", 32'(response_data_strobe), 32'd0);
        chk("abort_arm", 32'(response_start_write), 32'd0);
        @(negedge clock);
        chk("abort_start", 32'(response_start_write), 32'd1);
        @(negedge clock);
        chk("abort_busy", 32'(dev_busy), 32'd1);
        for (int i = 0; i < 5; i++) req_once(1'b1, 8'(8'h3A - i));
        req_once(1'b0, 8'h00);
        chk("abort_empty", 32'(response_data_empty), 32'd1);

        // Reset during SERVE with a simultaneous request
        start_xfer(9'd4);
        req_once(1'b1, 8'h39);
        @(negedge clock);
        reset = 1'b1;
        response_data_req = 1'b1;
        @(negedge clock);
        chk("rstmid_strobe", 32'(response_data_strobe), 32'd0);
        chk("rstmid_empty", 32'(response_data_empty), 32'd1);
        chk("rstmid_busy", 32'(dev_busy), 32'd0);
        reset = 1'b0;
        response_data_req = 1'b0;
        req_once(1'b0, 8'h00);

        // Zero-length transfer: first request goes straight to empty
        start_xfer(9'd0);
        req_once(1'b0, 8'h00);
        chk("zero_empty", 32'(response_data_empty), 32'd1);

`ifdef SDIO_RESP_LOOPBACK_EN
        send_cmd(5'h00, 1, 8'h03);
        send_cmd(5'h01, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            read_byte_strobe = 1'b1;
            read_byte = 8'(8'h11 * (i + 1));
        end
        @(negedge clock);
        read_byte_strobe = 1'b0;
        chk("lb_level", 32'(fifo_level), 32'd3);
        start_xfer(9'd3);
        req_once(1'b1, 8'h11);
        req_once(1'b1, 8'h22);
        req_once(1'b1, 8'h33);
`endif

        repeat (3) @(negedge clock);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("strobe_total", 32'(strobe_cnt), 32'(EXP_STROBES));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
